act_repacker: RTL and testbench

//  Downstream neighbour of the hidden-layer cluster. Consumes that cluster's activation stream:
//  48 beats of 4-bit activations, in order image0 n0..n15, image1 n0..n15, image2 n0..n15.
//  Re-packs them into 16 words of 12 bits, {img2[k],img1[k],img0[k]}, one per neuron k.
//  The packed words drive the x-stream of the next layer's cluster.

---
 rtl/act_repacker_pkg.sv | 48 ++++
 rtl/act_repacker_if.sv | 37 +++
 rtl/act_repacker_bank.sv | 24 ++
 rtl/act_repacker.sv | 107 ++++++++++
 tb/tb_act_repacker.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/act_repacker_pkg.sv
// Shared constants, lane types and the lane-packing helper for the activation repacker.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package act_repacker_pkg;

  localparam int NUM_NEURONS = 16;
  localparam int NUM_IMAGES  = 3;
  localparam int BITWIDTH    = 4;
  localparam int FRAME_BEATS = NUM_NEURONS * NUM_IMAGES;
  localparam int TDATA_W     = 64;
  localparam int WORD_W      = NUM_IMAGES * BITWIDTH;
  localparam int K_W         = $clog2(NUM_NEURONS);
  localparam int IMG_W       = $clog2(NUM_IMAGES);
  localparam int CNT_W       = $clog2(FRAME_BEATS);

  typedef logic [BITWIDTH-1:0] act_t;
  typedef logic [WORD_W-1:0]   word_t;
  typedef logic [K_W-1:0]      nidx_t;
  typedef logic [IMG_W-1:0]    iidx_t;
  typedef logic [CNT_W-1:0]    bcnt_t;

  // One write into a bank: which neuron row, which image lane, and the activation.
  typedef struct packed {
    logic  we;
    nidx_t k;
    iidx_t img;
    act_t  d;
  } bank_wr_t;

  localparam bcnt_t LAST_BEAT = bcnt_t'(FRAME_BEATS - 1);
  localparam nidx_t LAST_WORD = nidx_t'(NUM_NEURONS - 1);

  // Lane i of a packed word sits at [4i+3:4i]; the next layer unpacks with the same order.
  function automatic word_t pack_lanes(act_t a0, act_t a1, act_t a2);
    return {a2, a1, a0};
  endfunction

  // Beats arrive image-major, so the image index is the beat count divided by the neuron count.
  function automatic iidx_t beat_img(bcnt_t c);
    return iidx_t'(c / bcnt_t'(NUM_NEURONS));
  endfunction

  // Neuron index is the remainder within the current image.
  function automatic nidx_t beat_k(bcnt_t c);
    return nidx_t'(c % bcnt_t'(NUM_NEURONS));
  endfunction

endpackage

// File: rtl/act_repacker_if.sv
// Activation-in / packed-word-out stream bundle plus bank status.
// Latency: wires only.
// Backpressure: AXIS-style valid/ready on both streams.
interface act_repacker_if;
  import act_repacker_pkg::*;

  logic [TDATA_W-1:0] s_tdata;
  logic               s_tvalid;
  logic               s_tready;
  word_t              m_tdata;
  logic               m_tvalid;
  logic               m_tready;
  logic [1:0]         status;

  // Repacker side: consumes the activation stream, produces packed words.
  modport slave (
    input  s_tdata,
    input  s_tvalid,
    output s_tready,
    output m_tdata,
    output m_tvalid,
    input  m_tready,
    output status
  );

  // Neighbour side: produces activations, consumes packed words.
  modport master (
    output s_tdata,
    output s_tvalid,
    input  s_tready,
    input  m_tdata,
    input  m_tvalid,
    output m_tready,
    input  status
  );

endinterface

// File: rtl/act_repacker_bank.sv
// One frame of activations: 16 neuron rows x 3 image lanes x 4 bits, read as a packed row.
// Latency: write lands on the clock edge; read is combinational from the stored lanes.
// Backpressure: none here; the top only writes a bank that is not full.
module act_bank
  import act_repacker_pkg::*;
(
  input  logic     clk_i,
  input  bank_wr_t wr_i,
  input  nidx_t    rd_k_i,
  output word_t    rd_word_o
);

  act_t lane_q [NUM_NEURONS][NUM_IMAGES];

  // Store one activation into its neuron row and image lane; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (wr_i.we && (wr_i.img < iidx_t'(NUM_IMAGES))) begin
      lane_q[wr_i.k][wr_i.img] <= wr_i.d;
    end
  end

  assign rd_word_o = pack_lanes(lane_q[rd_k_i][0], lane_q[rd_k_i][1], lane_q[rd_k_i][2]);

endmodule

// File: rtl/act_repacker.sv
// Re-packs 48 image-major 4-bit activations into 16 neuron-major 12-bit words, ping-pong banked.
// Latency: last beat accepted at edge T gives m_tvalid from T+1 when that bank is being read.
// Backpressure: s_tready drops only while both banks hold unread frames; m_tdata holds while stalled.
module act_repacker
  import act_repacker_pkg::*;
(
  input  logic           CLK,
  input  logic           RST,
  act_repacker_if.slave  io
);

  logic       wr_bank_q, wr_bank_d;
  logic       rd_bank_q, rd_bank_d;
  bcnt_t      wr_cnt_q, wr_cnt_d;
  nidx_t      rd_cnt_q, rd_cnt_d;
  logic [1:0] full_q, full_d;

  logic       s_rdy;
  logic       wr_fire;
  logic       m_vld;
  logic       rd_fire;

  bank_wr_t   bank_wr [2];
  word_t      bank_rd [2];

  // Upper activation bits carry nothing; the upstream cluster already clamps to 4 bits.
  logic       unused_hi;
  assign unused_hi = ^io.s_tdata[TDATA_W-1:BITWIDTH];

  // Handshake qualifiers come from registered flags only; reset forces both sides idle.
  assign s_rdy   = RST & ~full_q[wr_bank_q];
  assign wr_fire = io.s_tvalid & s_rdy;
  assign m_vld   = RST & full_q[rd_bank_q];
  assign rd_fire = m_vld & io.m_tready;

  // Advance fill and drain pointers; the two sides always touch different banks.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    full_d    = full_q;

    if (wr_fire) begin
      if (wr_cnt_q == LAST_BEAT) begin
        wr_cnt_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + bcnt_t'(1);
      end
    end

    if (rd_fire) begin
      if (rd_cnt_q == LAST_WORD) begin
        rd_cnt_d          = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_cnt_d = rd_cnt_q + nidx_t'(1);
      end
    end
  end

  // Pointer, counter and full-flag registers; reset discards partial and completed frames.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      full_q    <= 2'b00;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
    end
  end

  // Steer each accepted beat to the filling bank at its neuron row and image lane.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_wr[b].we  = wr_fire & (wr_bank_q == 1'(b));
      bank_wr[b].k   = beat_k(wr_cnt_q);
      bank_wr[b].img = beat_img(wr_cnt_q);
      bank_wr[b].d   = io.s_tdata[BITWIDTH-1:0];
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    act_bank u_bank (
      .clk_i     (CLK),
      .wr_i      (bank_wr[b]),
      .rd_k_i    (rd_cnt_q),
      .rd_word_o (bank_rd[b])
    );
  end

  // Draining bank is full and never written, so the word stays stable across stalls.
  assign io.m_tdata  = m_vld ? bank_rd[rd_bank_q] : '0;
  assign io.m_tvalid = m_vld;
  assign io.s_tready = s_rdy;
  assign io.status   = RST ? full_q : 2'b00;

endmodule

// File: tb/tb_act_repacker.sv
// Directed bench for act_repacker with a queue-level frame model checked every cycle.
// Latency: drives inputs 1 time unit after each rising edge, checks on falling edges.
// Backpressure: exercises stalls, both-banks-full, coincident fill/drain and mid-frame reset.
module tb_act_repacker;
  import act_repacker_pkg::*;

  logic CLK = 1'b0;
  logic RST;

  act_repacker_if io ();

  act_repacker dut (
    .CLK (CLK),
    .RST (RST),
    .io  (io)
  );

  initial forever #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- frame model: beats in, completed frames as word queues ----------------
  logic [3:0]  m_part  [$];
  logic [11:0] m_words [$];
  bit          m_bank  [$];
  int          m_seq = 0;
  int          m_rd  = 0;

  function automatic int m_nfull();
    return m_words.size() / 16;
  endfunction

  initial begin
    forever begin
      @(posedge CLK);
      begin : model_step
        bit acc;
        bit rdf;
        if (RST !== 1'b1) begin
          m_part.delete();
          m_words.delete();
          m_bank.delete();
          m_seq = 0;
          m_rd  = 0;
        end else begin
          acc = (io.s_tvalid === 1'b1) && (m_nfull() < 2);
          rdf = (io.m_tready === 1'b1) && (m_nfull() > 0);
          if (rdf) begin
            m_rd++;
            if (m_rd == 16) begin
              m_rd = 0;
              repeat (16) void'(m_words.pop_front());
              void'(m_bank.pop_front());
            end
          end
          if (acc) begin
            m_part.push_back(io.s_tdata[3:0]);
            if (m_part.size() == 48) begin
              for (int k = 0; k < 16; k++)
                m_words.push_back({m_part[32+k], m_part[16+k], m_part[k]});
              m_bank.push_back(m_seq[0]);
              m_seq++;
              m_part.delete();
            end
          end
        end
      end
    end
  end

  bit chk_en = 1'b0;

  // Per-cycle compare of every output against the model.
  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin : cmp
        logic [1:0]  st;
        logic [11:0] dat;
        st = 2'b00;
        foreach (m_bank[i]) st[m_bank[i]] = 1'b1;
        if (RST !== 1'b1) st = 2'b00;
        dat = ((RST === 1'b1) && (m_nfull() > 0)) ? m_words[m_rd] : 12'h000;
        chk("cmp_s_tready", 64'(io.s_tready), 64'((RST === 1'b1) && (m_nfull() < 2)));
        chk("cmp_m_tvalid", 64'(io.m_tvalid), 64'((RST === 1'b1) && (m_nfull() > 0)));
        chk("cmp_m_tdata",  64'(io.m_tdata),  64'(dat));
        chk("cmp_status",   64'(io.status),   64'(st));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [3:0]  src_q  [$];
  logic [11:0] hs_log [$];
  logic [59:0] hi_fill = '0;
  int          mode    = 0;
  bit          alt_ph  = 1'b1;
  int          n_acc   = 0;
  bit          last_acc, last_hs, pre_vld;
  logic [1:0]  pre_status;

  function automatic logic [3:0] beat(int t, int j);
    int v;
    case (t)
      1:       v = 5 * (j / 16) + (j % 16);
      2:       v = 11 * j + 3 * (j / 16) + 5;
      3:       v = 7 * j + 5 * (j / 16) + 3;
      4:       v = 3 * j + (j / 16) + 1;
      default: v = 5 * j + 2 * (j / 16) + 9;
    endcase
    return 4'(v & 15);
  endfunction

  function automatic logic [11:0] word(int t, int base, int k);
    return {beat(t, base + 32 + k), beat(t, base + 16 + k), beat(t, base + k)};
  endfunction

  task automatic push_frame(int t, int base, int n);
    for (int j = 0; j < n; j++) src_q.push_back(beat(t, base + j));
  endtask

  task automatic cycle();
    bit          stall;
    logic [11:0] held;
    io.s_tvalid = (src_q.size() > 0);
    io.s_tdata  = (src_q.size() > 0) ? {hi_fill, src_q[0]} : 64'h0;
    case (mode)
      0:       io.m_tready = 1'b0;
      1:       io.m_tready = 1'b1;
      default: begin io.m_tready = alt_ph; alt_ph = ~alt_ph; end
    endcase
    @(posedge CLK);
    last_acc   = io.s_tvalid && io.s_tready;
    last_hs    = io.m_tvalid && io.m_tready;
    pre_vld    = io.m_tvalid;
    pre_status = io.status;
    stall      = io.m_tvalid && !io.m_tready;
    held       = io.m_tdata;
    if (last_acc) begin void'(src_q.pop_front()); n_acc++; end
    if (last_hs) hs_log.push_back(io.m_tdata);
    #1;
    if (stall) begin
      chk("hold_valid", 64'(io.m_tvalid), 64'h1);
      chk("hold_data", 64'(io.m_tdata), 64'(held));
    end
  endtask

  task automatic run_hs(int target, int budget, string nm);
    int c = 0;
    while (hs_log.size() < target && c < budget) begin cycle(); c++; end
    chk(nm, 64'(hs_log.size()), 64'(target));
  endtask

  task automatic run_src(int budget, string nm);
    int c = 0;
    while (src_q.size() > 0 && c < budget) begin cycle(); c++; end
    chk(nm, 64'(src_q.size()), 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    RST = 1'b0;
    io.s_tvalid = 1'b0;
    io.s_tdata  = 64'h0;
    io.m_tready = 1'b0;
    cycle();
    cycle();
    chk_en = 1'b1;
    chk("rst_s_tready", 64'(io.s_tready), 64'h0);
    chk("rst_m_tvalid", 64'(io.m_tvalid), 64'h0);
    chk("rst_m_tdata",  64'(io.m_tdata),  64'h0);
    chk("rst_status",   64'(io.status),   64'h0);
    RST = 1'b1;
    #1;
    chk("rel_s_tready", 64'(io.s_tready), 64'h1);

    // 1: one frame, free-flowing output
    mode = 1; n_acc = 0; hs_log.delete();
    push_frame(1, 0, 48);
    begin
      int c = 0;
      while (n_acc < 48 && c < 100) begin cycle(); c++; end
    end
    chk("t1_acc48",      64'(n_acc),       64'd48);
    chk("t1_vld_before", 64'(pre_vld),     64'h0);
    chk("t1_vld_after",  64'(io.m_tvalid), 64'h1);
    chk("t1_word0_lat",  64'(io.m_tdata),  64'hA50);
    run_hs(16, 50, "t1_words");
    chk("t1_w0",  64'(hs_log[0]),  64'hA50);
    chk("t1_w7",  64'(hs_log[7]),  64'h1C7);
    chk("t1_w15", 64'(hs_log[15]), 64'h94F);
    for (int k = 0; k < 16; k++) chk("t1_word", 64'(hs_log[k]), 64'(word(1, 0, k)));

    // 2: alternating m_tready, data held over stalls
    mode = 2; alt_ph = 1'b1; hs_log.delete();
    push_frame(2, 0, 48);
    run_hs(16, 200, "t2_words");
    chk("t2_w0", 64'(hs_log[0]), 64'hB85);
    for (int k = 0; k < 16; k++) chk("t2_word", 64'(hs_log[k]), 64'(word(2, 0, k)));

    // 3: both banks fill, input blocks, then frame A drains
    mode = 0; n_acc = 0; hs_log.delete();
    push_frame(3, 0, 100);
    repeat (120) cycle();
    chk("t3_acc96",    64'(n_acc),       64'd96);
    chk("t3_blocked",  64'(io.s_tready), 64'h0);
    chk("t3_status11", 64'(io.status),   64'h3);
    chk("t3_headword", 64'(io.m_tdata),  64'hD83);
    mode = 1;
    run_hs(16, 40, "t3_drainA");
    chk("t3_rdy_after", 64'(io.s_tready), 64'h1);
    chk("t3_status10",  64'(io.status),   64'h2);
    chk("t3_b_head",    64'(io.m_tdata),  64'hC72);
    for (int k = 0; k < 16; k++) chk("t3_word", 64'(hs_log[k]), 64'(word(3, 0, k)));
    mode = 0;

    // 5: reset after 20 beats of a partial frame while frame B waits
    push_frame(3, 100, 16);
    run_src(60, "t5_fill20");
    chk("t5_acc",     64'(n_acc),       64'd116);
    chk("t5_status",  64'(io.status),   64'h2);
    chk("t5_vld_pre", 64'(io.m_tvalid), 64'h1);
    io.s_tvalid = 1'b1;
    io.s_tdata  = {hi_fill, 4'h9};
    RST = 1'b0;
    #1;
    chk("t5_rst_s_tready", 64'(io.s_tready), 64'h0);
    chk("t5_rst_m_tvalid", 64'(io.m_tvalid), 64'h0);
    chk("t5_rst_status",   64'(io.status),   64'h0);
    chk("t5_rst_m_tdata",  64'(io.m_tdata),  64'h0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    io.s_tvalid = 1'b0;
    src_q.delete();
    #1;
    chk("t5_post_s_tready", 64'(io.s_tready), 64'h1);
    chk("t5_post_m_tvalid", 64'(io.m_tvalid), 64'h0);
    chk("t5_post_status",   64'(io.status),   64'h0);

    // 4: frame B's last accept coincides with frame A's last handshake
    mode = 0; n_acc = 0; hi_fill = '0;
    push_frame(4, 0, 48);
    push_frame(5, 0, 32);
    run_src(200, "t4_fill");
    chk("t4_acc80",    64'(n_acc),     64'd80);
    chk("t4_status01", 64'(io.status), 64'h1);
    push_frame(5, 32, 16);
    mode = 1; hs_log.delete();
    repeat (16) cycle();
    chk("t4_acc_last",     64'(last_acc),      64'h1);
    chk("t4_hs_last",      64'(last_hs),       64'h1);
    chk("t4_hs16",         64'(hs_log.size()), 64'd16);
    chk("t4_status_pre",   64'(pre_status),    64'h1);
    chk("t4_status_post",  64'(io.status),     64'h2);
    chk("t4_no_gap",       64'(io.m_tvalid),   64'h1);
    chk("t4_b_word0",      64'(io.m_tdata),    64'hDB9);
    run_hs(32, 40, "t4_drainB");
    for (int k = 0; k < 16; k++) begin
      chk("t4_a_word", 64'(hs_log[k]),      64'(word(4, 0, k)));
      chk("t4_b_word", 64'(hs_log[16 + k]), 64'(word(5, 0, k)));
    end

    // 6: junk in the upper data bits is ignored
    hi_fill = '1; mode = 1; hs_log.delete();
    for (int j = 0; j < 48; j++) src_q.push_back(4'h3);
    run_hs(16, 100, "t6_words");
    for (int k = 0; k < 16; k++) chk("t6_word", 64'(hs_log[k]), 64'h333);

    repeat (3) cycle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
